ssd_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the common-anode 14-segment display bank.

---
 rtl/ssd_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scan_ctrl
//  Purpose  : Time-multiplexed 14-segment scan controller with frame-synchronous
//             load/ack, leading-zero blanking and dead-cycle digit switching.
//             Optional blink support is enabled with the SSD_BLINK_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 100000
`ifdef SSD_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 256
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    blank_lz,
`ifdef SSD_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic                    ack,
   output logic                    frame_start,
   output logic [3:0]              bcd,
   output logic [NUM_DIGITS-1:0]   digit_en
);

   localparam int c_cnt_w = $clog2(SCAN_DIV);
   localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
   localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

   logic [c_cnt_w-1:0]      r_cnt;
   logic [c_idx_w-1:0]      r_idx;
   logic [4*NUM_DIGITS-1:0] r_pend;
   logic                    r_pending;
   logic [4*NUM_DIGITS-1:0] r_shadow;

   logic                    w_tick;
   logic                    w_wrap;
   logic [NUM_DIGITS-1:0]   w_zero_from;
   logic [NUM_DIGITS-1:0]   w_sel_n;
   logic [NUM_DIGITS-1:0]   w_en;
   logic [3:0]              w_digit;
   logic [3:0]              w_code;
   logic                    w_lz;

   assign w_tick = (r_cnt == c_cnt_last);
   assign w_wrap = w_tick && (r_idx == c_idx_last);

   // w_zero_from[g]: digit g and every more significant digit are zero
   generate
      for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
         assign w_zero_from[g] = (r_shadow[4*NUM_DIGITS-1 : 4*g] == '0);
      end
   endgenerate

`ifdef SSD_BLINK_EN
   localparam int c_fc_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [c_fc_w-1:0] c_fc_last = c_fc_w'(BLINK_FRAMES - 1);

   logic [c_fc_w-1:0] r_frame_cnt;
   logic              r_phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (w_wrap) begin
         if (r_frame_cnt == c_fc_last) begin
            r_frame_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end
`endif

   always_comb begin
      w_digit = 4'd15;
      w_sel_n = '1;
      w_lz    = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == c_idx_w'(i)) begin
            w_digit    = r_shadow[4*i +: 4];
            w_sel_n[i] = 1'b0;
            w_lz       = w_zero_from[i];
         end
      end
      // First cycle of each slot is dark so the anode switch never ghosts
      w_en   = (r_cnt == '0) ? '1 : w_sel_n;
      w_code = (blank_lz && (r_idx != '0) && w_lz) ? 4'd15 : w_digit;
`ifdef SSD_BLINK_EN
      if (r_phase && |(blink_mask & ~w_sel_n)) begin
         w_code = 4'd15;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_pend      <= '0;
         r_pending   <= 1'b0;
         r_shadow    <= '1;
         ack         <= 1'b0;
         frame_start <= 1'b0;
         bcd         <= 4'd15;
         digit_en    <= '1;
      end else begin
         r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         if (w_tick) begin
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
         end

         frame_start <= w_wrap;
         ack         <= w_wrap && (r_pending || load);

         // Shadow only moves on the wrap edge, so a frame never tears
         if (w_wrap) begin
            if (load) begin
               r_shadow <= value_in;
            end else if (r_pending) begin
               r_shadow <= r_pend;
            end
            r_pending <= 1'b0;
         end else if (load) begin
            r_pend    <= value_in;
            r_pending <= 1'b1;
         end

         bcd      <= w_code;
         digit_en <= w_en;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssd_scan_ctrl
//  Purpose  : Scoreboard bench for ssd_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_ctrl;

   localparam int N   = 4;
   localparam int DIV = 4;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        load     = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] value_in = 16'h0;
   logic        ack;
   logic        frame_start;
   logic [3:0]  bcd;
   logic [3:0]  digit_en;
`ifdef SSD_BLINK_EN
   logic [3:0]  blink_mask = 4'h0;
`endif

   ssd_scan_ctrl #(
      .NUM_DIGITS (N),
      .SCAN_DIV   (DIV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .value_in    (value_in),
      .blank_lz    (blank_lz),
`ifdef SSD_BLINK_EN
      .blink_mask  (blink_mask),
`endif
      .ack         (ack),
      .frame_start (frame_start),
      .bcd         (bcd),
      .digit_en    (digit_en)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] en;
      logic [3:0] code;
   } slot_t;

   slot_t       exp_q[$];
   bit          ack_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   bit          done  = 1'b0;
   logic [15:0] m_shadow  = 16'hFFFF;
   logic [15:0] m_pend    = 16'h0;
   bit          m_pending = 1'b0;

   function automatic logic [3:0] exp_code(logic [15:0] v, int i, logic blz);
      logic [15:0] up;
      up = v >> (4 * i);
      if (blz && (i != 0) && (up == 16'd0)) return 4'd15;
      return up[3:0];
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_frame(logic blz);
      slot_t s;
      for (int i = 0; i < N; i++) begin
         s.en    = 4'b1111;
         s.en[i] = 1'b0;
         s.code  = exp_code(m_shadow, i, blz);
         exp_q.push_back(s);
      end
   endtask

   // Mid-frame load: only the first load of a frame earns an ack
   task automatic pulse_load(logic [15:0] v);
      value_in = v;
      load     = 1'b1;
      if (!m_pending) ack_q.push_back(1'b1);
      m_pend    = v;
      m_pending = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic frame_begin(logic blz);
      blank_lz = blz;
      if (m_pending) begin
         m_shadow  = m_pend;
         m_pending = 1'b0;
      end
      push_frame(blz);
   endtask

   task automatic wait_fs();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!frame_start && t < 40);
      if (!frame_start) begin
         n_vec++;
         n_err++;
         $display("FAIL frame_wait: no frame_start within 40 cycles, expected a pulse");
      end
   endtask

   task automatic wait_frame(logic blz);
      wait_fs();
      frame_begin(blz);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      ack_q.delete();
      m_shadow  = 16'hFFFF;
      m_pending = 1'b0;
      blank_lz  = 1'b0;
      load      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bcd", 32'(bcd), 32'd15);
      check("rst_digit_en", 32'(digit_en), 32'hF);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      push_frame(1'b0);
      rst = 1'b0;
   endtask

   // Monitor: pops one expected slot at each lit-slot start, checks slot length and acks
   initial begin
      logic [3:0] prev_en;
      int         lit;
      slot_t      s;
      prev_en = 4'hF;
      lit     = 0;
      forever begin
         @(negedge clk);
         if (done) break;
         if (rst) begin
            lit = 0;
         end else begin
            if (digit_en != 4'hF) begin
               if (prev_en == 4'hF) begin
                  if (exp_q.size() == 0) begin
                     n_vec++;
                     n_err++;
                     $display("FAIL unexpected_slot: got en=%b bcd=%0d, expected none", digit_en, bcd);
                  end else begin
                     s = exp_q.pop_front();
                     check("slot_en_bcd", 32'({digit_en, bcd}), 32'(s));
                  end
               end
               lit++;
            end else if (prev_en != 4'hF) begin
               check("slot_len", 32'(lit), 32'(DIV - 1));
               lit = 0;
            end
            if (ack) begin
               if (ack_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_ack: got ack=1, expected 0 (t=%0t)", $time);
               end else begin
                  void'(ack_q.pop_front());
                  check("ack_with_frame_start", 32'(frame_start), 32'd1);
               end
            end
         end
         prev_en = digit_en;
      end
   end

   initial begin
      // Reset and first tick timing
      do_reset();
      repeat (4) @(negedge clk);
      check("first_slot_lit", 32'(digit_en), 32'hE);
      @(negedge clk);
      check("first_tick_dead", 32'(digit_en), 32'hF);

      // Mid-frame load
      pulse_load(16'h1234);
      wait_frame(1'b0);

      // Leading-zero blanking
      pulse_load(16'h0070);
      wait_frame(1'b1);
      pulse_load(16'h0000);
      wait_frame(1'b1);
      wait_frame(1'b0);

      // Two loads in one frame: last wins, single ack
      pulse_load(16'h1111);
      repeat (3) @(negedge clk);
      pulse_load(16'h2222);
      wait_frame(1'b0);

      // Load exactly on the wrap cycle
      repeat (15) @(negedge clk);
      value_in = 16'h5678;
      load     = 1'b1;
      ack_q.push_back(1'b1);
      m_shadow  = 16'h5678;
      m_pending = 1'b0;
      @(negedge clk);
      load = 1'b0;
      check("wrap_aligned_load", 32'(frame_start), 32'd1);
      frame_begin(1'b0);

      // Load then reset before wrap: data and ack discarded
      repeat (3) @(negedge clk);
      pulse_load(16'h9999);
      repeat (2) @(negedge clk);
      do_reset();
      wait_frame(1'b0);

      wait_fs();
      @(negedge clk);
      #1 done = 1'b1;
      check("slot_queue_drained", 32'(exp_q.size()), 32'd0);
      check("ack_queue_drained", 32'(ack_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
